// File: rtl/debug_tx_arbiter.sv
// debug_tx_arbiter: round-robin sharing of one debug uart_tx among NUM_REQ
// frame-oriented byte sources. A granted requester keeps the transmitter for a
// whole frame. Each byte is sent with a tx_start pulse, and the arbiter follows
// tx_busy through the full character.
//
// Ports:
//   clk_in, reset            clock, asynchronous active-high reset
//   req[NUM_REQ]             per-requester frame request (held for the frame)
//   req_data[NUM_REQ*8]      byte from requester i on [8i+7:8i]
//   req_last[NUM_REQ]        marks req_data[i] as the final byte of the frame
//   grant[NUM_REQ]           one-hot (or zero) transmitter owner
//   byte_ack[NUM_REQ]        one-cycle pulse: byte consumed, present the next
//   tx_start, tx_data[8]     to uart_tx i_start / i_data
//   tx_busy                  from uart_tx o_busy
//   active                   high while grant is nonzero
//   abort_pulse              one-cycle pulse when the owner drops req mid-frame
module debug_tx_arbiter #(
    parameter int unsigned NUM_REQ            = 2,
    parameter int unsigned BUSY_TIMEOUT       = 4,
    parameter int unsigned BUSY_TIMEOUT_WIDTH = 3
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*8-1:0]    req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      byte_ack,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_busy,
    output logic                    active,
    output logic                    abort_pulse
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = BUSY_TIMEOUT_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     owner, owner_nxt;
    logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 last_flag, last_flag_nxt;
    logic [NUM_REQ-1:0]   grant_nxt, byte_ack_nxt;
    logic                 tx_start_nxt, active_nxt, abort_pulse_nxt;
    logic [7:0]           tx_data_nxt;

    // Round-robin pick: first set req starting just after rr_ptr.
    logic [PTR_W-1:0]     pick;
    logic [PTR_W-1:0]     idx;
    logic                 found;

    always_comb begin
        pick  = rr_ptr;
        idx   = rr_ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= PTR_W'(NUM_REQ - 1);
            cnt         <= '0;
            last_flag   <= 1'b0;
            grant       <= '0;
            byte_ack    <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            active      <= 1'b0;
            abort_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            rr_ptr      <= rr_ptr_nxt;
            cnt         <= cnt_nxt;
            last_flag   <= last_flag_nxt;
            grant       <= grant_nxt;
            byte_ack    <= byte_ack_nxt;
            tx_start    <= tx_start_nxt;
            tx_data     <= tx_data_nxt;
            active      <= active_nxt;
            abort_pulse <= abort_pulse_nxt;
        end
    end

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        rr_ptr_nxt      = rr_ptr;
        cnt_nxt         = cnt;
        last_flag_nxt   = last_flag;
        grant_nxt       = grant;
        byte_ack_nxt    = '0;
        tx_start_nxt    = 1'b0;
        tx_data_nxt     = tx_data;
        active_nxt      = active;
        abort_pulse_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt  = pick;
                    grant_nxt  = NUM_REQ'(1) << pick;
                    active_nxt = 1'b1;
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                if (!req[owner]) begin
                    // Owner abandoned the frame; rr_ptr is left alone.
                    grant_nxt       = '0;
                    active_nxt      = 1'b0;
                    abort_pulse_nxt = 1'b1;
                    state_nxt       = IDLE;
                end else begin
                    tx_data_nxt   = req_data[{owner, 3'b000} +: 8];
                    last_flag_nxt = req_last[owner];
                    byte_ack_nxt  = grant;
                    tx_start_nxt  = 1'b1;
                    state_nxt     = START;
                end
            end
            START: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                // Give up on busy after BUSY_TIMEOUT so a dead uart cannot hang us.
                if (tx_busy || (cnt == CNT_W'(BUSY_TIMEOUT))) begin
                    state_nxt = WAIT_LO;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_flag) begin
                        rr_ptr_nxt = owner;
                        grant_nxt  = '0;
                        active_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_tx_arbiter.sv
// Scoreboard bench for debug_tx_arbiter with two requesters and a uart_tx model.
module tb_debug_tx_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned CHAR_CYCLES = 10;

    logic               clk_in;
    logic               reset;
    logic [NUM_REQ-1:0] req;
    logic [15:0]        req_data;
    logic [NUM_REQ-1:0] req_last;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] byte_ack;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic               active;
    logic               abort_pulse;

    debug_tx_arbiter #(
        .NUM_REQ            (NUM_REQ),
        .BUSY_TIMEOUT       (4),
        .BUSY_TIMEOUT_WIDTH (3)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .grant       (grant),
        .byte_ack    (byte_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .active      (active),
        .abort_pulse (abort_pulse)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // uart_tx model: busy for CHAR_CYCLES after each start, or never when dead.
    logic dead;
    int   busy_cnt = 0;
    always @(posedge clk_in) begin
        if (tx_start && !dead) busy_cnt <= CHAR_CYCLES;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    typedef struct packed {
        logic [7:0]  owner;
        logic [7:0]  data;
        logic [15:0] gap;   // expected cycles since previous tx_start, 0 = don't care
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_start = 0;
    int n_starts = 0;
    int n_abort_cyc = 0;
    logic [NUM_REQ-1:0] abort_grant;
    logic abort_active;
    logic drop0;

    task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic drive();
        req[0]          = (q0.size() != 0);
        req_data[7:0]   = (q0.size() != 0) ? q0[0] : 8'h00;
        req_last[0]     = (q0.size() == 1);
        req[1]          = (q1.size() != 0);
        req_data[15:8]  = (q1.size() != 0) ? q1[0] : 8'h00;
        req_last[1]     = (q1.size() == 1);
    endtask

    // One cycle: observe outputs at negedge, score them, then update requesters.
    task automatic tick();
        exp_t e;
        @(negedge clk_in);
        cyc++;
        if (tx_start) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_start", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("tx_data", tx_data, e.data);
                check_val("grant_at_start", grant, 1 << e.owner);
                check_val("byte_ack", byte_ack, 1 << e.owner);
                if (e.gap != 0) check_val("start_gap", cyc - last_start, e.gap);
            end
            last_start = cyc;
            n_starts++;
        end else if (byte_ack != 0) begin
            check_val("ack_without_start", byte_ack, 0);
        end
        if (abort_pulse) begin
            n_abort_cyc++;
            abort_grant  = grant;
            abort_active = active;
        end
        if (byte_ack[0] && q0.size() != 0) begin
            void'(q0.pop_front());
            if (drop0) begin
                q0.delete();
                drop0 = 1'b0;
            end
        end
        if (byte_ack[1] && q1.size() != 0) void'(q1.pop_front());
        drive();
    endtask

    // Queue a frame (byte k in bits [8k+7:8k]); only the first n_exp bytes are expected on the wire.
    task automatic add_frame(input int idx, input int n, input logic [23:0] b,
                             input int first_gap, input int n_exp);
        exp_t e;
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            d = b[8*k +: 8];
            if (idx == 0) q0.push_back(d);
            else          q1.push_back(d);
            if (k < n_exp) begin
                e.owner = 8'(idx);
                e.data  = d;
                e.gap   = 16'((k == 0) ? first_gap : (dead ? 8 : 13));
                exp_q.push_back(e);
            end
        end
        drive();
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (k < budget && !(exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0
                               && !active && !tx_busy)) begin
            tick();
            k++;
        end
        check_val("idle_reached", (k < budget) ? 1 : 0, 1);
        check_val("grant_idle", grant, 0);
    endtask

    task automatic wait_start(input int budget);
        int s = n_starts;
        for (int k = 0; k < budget && n_starts == s; k++) tick();
        if (n_starts == s) check_val("start_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int s0, a0;
        reset = 1'b1;
        dead  = 1'b0;
        drop0 = 1'b0;
        req = '0; req_data = '0; req_last = '0;
        repeat (2) tick();
        check_val("rst_grant", grant, 0);
        check_val("rst_byte_ack", byte_ack, 0);
        check_val("rst_tx_start", tx_start, 0);
        check_val("rst_tx_data", tx_data, 0);
        check_val("rst_active", active, 0);
        check_val("rst_abort", abort_pulse, 0);
        reset = 1'b0;
        tick();

        // Single requester, 3-byte frame.
        add_frame(0, 3, 24'h0A4241, 0, 3);
        wait_idle(400);
        check_val("active_idle", active, 0);

        // Simultaneous requests after reset: 0 then 1.
        pulse_reset();
        add_frame(0, 2, 24'h001211, 0, 2);
        add_frame(1, 2, 24'h002221, 14, 2);
        wait_idle(400);

        // Again: rr_ptr=1, so 0 wins; single-byte frames.
        add_frame(0, 1, 24'h000031, 0, 1);
        add_frame(1, 1, 24'h000032, 14, 1);
        wait_idle(400);

        // Requester 1 arrives mid-frame and must wait.
        add_frame(0, 3, 24'h535251, 0, 3);
        wait_start(100);
        add_frame(1, 2, 24'h006261, 14, 2);
        repeat (5) tick();
        check_val("grant_hold", grant, 1);
        wait_idle(400);

        // Owner drops req after its first byte.
        s0 = n_starts;
        a0 = n_abort_cyc;
        drop0 = 1'b1;
        add_frame(0, 3, 24'h737271, 0, 1);
        for (int k = 0; k < 100 && n_abort_cyc == a0; k++) tick();
        repeat (20) tick();
        check_val("abort_width", n_abort_cyc - a0, 1);
        check_val("abort_grant", abort_grant, 0);
        check_val("abort_active", abort_active, 0);
        check_val("abort_starts", n_starts - s0, 1);
        wait_idle(400);
        // rr_ptr still 1 after the abort: 0 wins again.
        add_frame(0, 1, 24'h000055, 0, 1);
        add_frame(1, 1, 24'h000066, 14, 1);
        wait_idle(400);

        // Dead transmitter: timeout paces each byte.
        dead = 1'b1;
        add_frame(0, 3, 24'h838281, 0, 3);
        wait_idle(400);
        dead = 1'b0;

        // Reset during WAIT_LO of requester 1's frame (rr_ptr=0 before reset).
        add_frame(1, 2, 24'h009291, 0, 1);
        wait_start(100);
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check_val("async_grant", grant, 0);
        check_val("async_tx_start", tx_start, 0);
        check_val("async_active", active, 0);
        check_val("async_byte_ack", byte_ack, 0);
        check_val("async_tx_data", tx_data, 0);
        q1.delete();
        exp_q.delete();
        drive();
        repeat (2) tick();
        reset = 1'b0;
        repeat (12) tick();
        add_frame(0, 1, 24'h0000A5, 0, 1);
        add_frame(1, 1, 24'h0000B5, 14, 1);
        wait_idle(400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
